sparse_pe: RTL and testbench

//  Sparse-CNN processing element (SCNN-style Cartesian-product multiplier array).
//  - Each accepted beat multiplies one nonzero weight by four nonzero activations.
//  - Each product is tagged with the output (col,row) coordinate it contributes to.
//  - Sits between the compressed weight/activation fetch logic and the scatter/accumulator bank.

---
 rtl/sparse_pe_pkg.sv | 30 +++
 rtl/sparse_pe_lane.sv | 51 +++++
 rtl/sparse_pe.sv | 111 +++++++++++
 tb/tb_sparse_pe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pe_pkg.sv
// Shared parameters, lane coordinate type and product saturation for the sparse PE.
package sparse_pe_pkg;

  localparam int col_length       = 5;
  localparam int wordlength       = 16;
  localparam int doublewordLength = 16;
  localparam int kernel_size      = 5;
  localparam int LANES            = 4;
  localparam int PIPE_LAT         = 2;
  localparam int PROD_W           = 2 * wordlength;

  typedef struct packed {
    logic [col_length-1:0] col;
    logic [col_length-1:0] row;
  } lane_coord_t;

  // Clamp a full-width signed product into the signed output width.
  function automatic logic signed [doublewordLength-1:0] saturate(
    input logic signed [PROD_W-1:0] p
  );
    logic signed [PROD_W-1:0] max_v;
    logic signed [PROD_W-1:0] min_v;
    max_v = {{(PROD_W-doublewordLength+1){1'b0}}, {(doublewordLength-1){1'b1}}};
    min_v = {{(PROD_W-doublewordLength+1){1'b1}}, {(doublewordLength-1){1'b0}}};
    if (p > max_v)      return max_v[doublewordLength-1:0];
    else if (p < min_v) return min_v[doublewordLength-1:0];
    else                return p[doublewordLength-1:0];
  endfunction

endpackage

// File: rtl/sparse_pe_lane.sv
// One multiplier lane: multiply/saturate, coordinate subtract, range check, output register.
// Optional ZERO_SKIP_EN suppresses products with a zero weight or activation.
module sparse_pe_lane
  import sparse_pe_pkg::*;
(
  input  logic                               clk,
  input  logic                               irst_n,
  input  logic                               beat_valid,
  input  logic signed [wordlength-1:0]       weight,
  input  logic signed [wordlength-1:0]       act,
  input  lane_coord_t                        w_coord,
  input  lane_coord_t                        d_coord,
  output logic signed [doublewordLength-1:0] product,
  output lane_coord_t                        out_coord,
  output logic                               out_valid
);

  logic signed [PROD_W-1:0] prod_full;
  logic                     in_range;
  logic                     nonzero;
  logic                     lane_ok;
  lane_coord_t              diff;

  assign prod_full = weight * act;
  assign in_range  = (d_coord.col >= w_coord.col) && (d_coord.row >= w_coord.row);
  // Subtraction wraps modulo 2^col_length; out-of-range lanes are flagged, not clamped.
  assign diff.col  = d_coord.col - w_coord.col;
  assign diff.row  = d_coord.row - w_coord.row;

`ifdef ZERO_SKIP_EN
  assign nonzero = (act != '0) && (weight != '0);
`else
  assign nonzero = 1'b1;
`endif

  assign lane_ok = beat_valid && in_range && nonzero;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge irst_n) begin
    if (irst_n) begin
      product   <= '0;
      out_coord <= '0;
      out_valid <= 1'b0;
    end else begin
      product   <= lane_ok ? saturate(prod_full) : '0;
      out_coord <= diff;
      out_valid <= lane_ok;
    end
  end

endmodule

// File: rtl/sparse_pe.sv
// Sparse-CNN PE top: input register, pixel/weight beat counters, tag pipeline, 4 lanes.
// Build with ZERO_SKIP_EN defined to gate zero-operand products.
module sparse_pe
  import sparse_pe_pkg::*;
(
  input  logic                                clk,
  input  logic                                irst_n,
  input  logic                                in_valid,
  input  logic [15:0]                         pixels,
  input  logic [5:0]                          in_channel,
  input  logic [col_length-1:0]               weight_cols,
  input  logic [col_length-1:0]               weight_rows,
  input  logic [wordlength-1:0]               weight,
  input  logic [LANES*col_length-1:0]         data_in_cols,
  input  logic [LANES*col_length-1:0]         data_in_rows,
  input  logic [LANES*wordlength-1:0]         data_in,
  output logic [5:0]                          out_channel,
  output logic [LANES*doublewordLength-1:0]   data_out,
  output logic [LANES*col_length-1:0]         data_out_cols,
  output logic [LANES*col_length-1:0]         data_out_rows,
  output logic [LANES-1:0]                    out_valid,
  output logic [15:0]                         curr_pixel,
  output logic [15:0]                         curr_weight
);

  logic                        s1_valid;
  logic [wordlength-1:0]       s1_weight;
  lane_coord_t                 s1_wcoord;
  logic [LANES*col_length-1:0] s1_cols;
  logic [LANES*col_length-1:0] s1_rows;
  logic [LANES*wordlength-1:0] s1_data;
  logic [5:0]                  s1_channel;
  logic [15:0]                 s1_pixel;
  logic [15:0]                 s1_wtag;

  logic [15:0] pix_cnt;
  logic [15:0] wgt_cnt;
  logic [15:0] pix_eff;
  logic [16:0] pix_inc;
  logic        pix_wrap;

  // A pixels value of 0 behaves as 1; >= also covers pixels shrinking below the count.
  assign pix_eff  = (pixels == '0) ? 16'd1 : pixels;
  assign pix_inc  = {1'b0, pix_cnt} + 17'd1;
  assign pix_wrap = pix_inc >= {1'b0, pix_eff};

  always_ff @(posedge clk or posedge irst_n) begin
    if (irst_n) begin
      pix_cnt <= '0;
      wgt_cnt <= '0;
    end else if (in_valid) begin
      pix_cnt <= pix_wrap ? 16'd0 : pix_inc[15:0];
      wgt_cnt <= pix_wrap ? wgt_cnt + 16'd1 : wgt_cnt;
    end
  end

  always_ff @(posedge clk or posedge irst_n) begin
    if (irst_n) begin
      s1_valid    <= 1'b0;
      s1_weight   <= '0;
      s1_wcoord   <= '0;
      s1_cols     <= '0;
      s1_rows     <= '0;
      s1_data     <= '0;
      s1_channel  <= '0;
      s1_pixel    <= '0;
      s1_wtag     <= '0;
      out_channel <= '0;
      curr_pixel  <= '0;
      curr_weight <= '0;
    end else begin
      s1_valid    <= in_valid;
      s1_weight   <= weight;
      s1_wcoord   <= '{col: weight_cols, row: weight_rows};
      s1_cols     <= data_in_cols;
      s1_rows     <= data_in_rows;
      s1_data     <= data_in;
      s1_channel  <= in_channel;
      s1_pixel    <= pix_cnt;
      s1_wtag     <= wgt_cnt;
      out_channel <= s1_channel;
      curr_pixel  <= s1_pixel;
      curr_weight <= s1_wtag;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_coord_t d_coord;
    lane_coord_t o_coord;

    assign d_coord = '{col: s1_cols[i*col_length +: col_length],
                       row: s1_rows[i*col_length +: col_length]};

    sparse_pe_lane u_lane (
      .clk        (clk),
      .irst_n     (irst_n),
      .beat_valid (s1_valid),
      .weight     (s1_weight),
      .act        (s1_data[i*wordlength +: wordlength]),
      .w_coord    (s1_wcoord),
      .d_coord    (d_coord),
      .product    (data_out[i*doublewordLength +: doublewordLength]),
      .out_coord  (o_coord),
      .out_valid  (out_valid[i])
    );

    assign data_out_cols[i*col_length +: col_length] = o_coord.col;
    assign data_out_rows[i*col_length +: col_length] = o_coord.row;
  end

endmodule

// File: tb/tb_sparse_pe.sv
// Directed self-checking bench for sparse_pe with hand-computed expected values.
// Expectations for the zero-lane case follow ZERO_SKIP_EN.
module tb_sparse_pe;

  logic        clk = 1'b0;
  logic        irst_n;
  logic        in_valid;
  logic [15:0] pixels;
  logic [5:0]  in_channel;
  logic [4:0]  weight_cols;
  logic [4:0]  weight_rows;
  logic [15:0] weight;
  logic [19:0] data_in_cols;
  logic [19:0] data_in_rows;
  logic [63:0] data_in;
  logic [5:0]  out_channel;
  logic [63:0] data_out;
  logic [19:0] data_out_cols;
  logic [19:0] data_out_rows;
  logic [3:0]  out_valid;
  logic [15:0] curr_pixel;
  logic [15:0] curr_weight;

  int total = 0;
  int bad   = 0;

  sparse_pe dut (
    .clk           (clk),
    .irst_n        (irst_n),
    .in_valid      (in_valid),
    .pixels        (pixels),
    .in_channel    (in_channel),
    .weight_cols   (weight_cols),
    .weight_rows   (weight_rows),
    .weight        (weight),
    .data_in_cols  (data_in_cols),
    .data_in_rows  (data_in_rows),
    .data_in       (data_in),
    .out_channel   (out_channel),
    .data_out      (data_out),
    .data_out_cols (data_out_cols),
    .data_out_rows (data_out_rows),
    .out_valid     (out_valid),
    .curr_pixel    (curr_pixel),
    .curr_weight   (curr_weight)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " data_out"}, data_out, 64'd0);
    check({tag, " cols"}, data_out_cols, 64'd0);
    check({tag, " rows"}, data_out_rows, 64'd0);
    check({tag, " valid"}, out_valid, 64'd0);
    check({tag, " channel"}, out_channel, 64'd0);
    check({tag, " pixel"}, curr_pixel, 64'd0);
    check({tag, " weight"}, curr_weight, 64'd0);
  endtask

  logic [3:0] zero_lane_valid;

  initial begin
    irst_n       = 1'b1;
    in_valid     = 1'b0;
    pixels       = 16'd4;
    in_channel   = '0;
    weight_cols  = '0;
    weight_rows  = '0;
    weight       = '0;
    data_in_cols = '0;
    data_in_rows = '0;
    data_in      = '0;

    // Reset with no traffic.
    step();
    step();
    check_all_zero("reset");
    irst_n = 1'b0;
    step();

    // Basic beat, 2-cycle latency.
    weight       = 16'd1;
    weight_cols  = 5'd1;
    weight_rows  = 5'd2;
    data_in      = {16'd4, 16'd3, 16'd2, 16'd1};
    data_in_cols = {5'd6, 5'd5, 5'd4, 5'd3};
    data_in_rows = {5'd3, 5'd4, 5'd5, 5'd6};
    in_channel   = 6'd5;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("basic data", data_out, {16'd4, 16'd3, 16'd2, 16'd1});
    check("basic cols", data_out_cols, {5'd5, 5'd4, 5'd3, 5'd2});
    check("basic rows", data_out_rows, {5'd1, 5'd2, 5'd3, 5'd4});
    check("basic valid", out_valid, 4'hF);
    check("basic channel", out_channel, 6'd5);
    check("basic pixel", curr_pixel, 16'd0);
    check("basic weight", curr_weight, 16'd0);
    step();
    check("idle valid", out_valid, 4'h0);
    check("idle data", data_out, 64'd0);

    // Reset asserted mid-stream with one beat on the outputs and one in flight.
    in_valid = 1'b1;
    step();
    step();
    check("pre-reset valid", out_valid, 4'hF);
    #2;
    irst_n   = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midreset valid", out_valid, 4'h0);
    check("midreset data", data_out, 64'd0);
    check("midreset channel", out_channel, 6'd0);
    step();
    irst_n = 1'b0;
    step();
    check("discarded valid", out_valid, 4'h0);

    // 32 back-to-back beats, pixels=15.
    pixels       = 16'd15;
    weight_cols  = '0;
    weight_rows  = '0;
    data_in_cols = '0;
    data_in_rows = '0;
    in_channel   = 6'd9;
    for (int i = 0; i < 32; i++) begin
      weight   = 16'(i + 1);
      data_in  = {16'(i + 4), 16'(i + 3), 16'(i + 2), 16'(i + 1)};
      in_valid = 1'b1;
      step();
      if (i == 15) begin
        // Beat 14 (pixel 14, weight 0) is on the outputs now.
        check("burst mid pixel", curr_pixel, 16'd14);
        check("burst mid weight", curr_weight, 16'd0);
      end
    end
    in_valid = 1'b0;
    step();
    check("burst data", data_out, {16'd1120, 16'd1088, 16'd1056, 16'd1024});
    check("burst valid", out_valid, 4'hF);
    check("burst pixel", curr_pixel, 16'd1);
    check("burst weight", curr_weight, 16'd2);
    check("burst channel", out_channel, 6'd9);

    // Saturation in both directions.
    weight   = 16'd300;
    data_in  = {16'd1, 16'd1, 16'hFF38, 16'd200};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("sat pos", data_out[15:0], 16'h7FFF);
    check("sat neg", data_out[31:16], 16'h8000);
    check("sat lane2", data_out[47:32], 16'd300);

    // Column range check with modulo coordinates.
    weight       = 16'd1;
    weight_cols  = 5'd4;
    weight_rows  = 5'd0;
    data_in      = {16'd1, 16'd1, 16'd1, 16'd1};
    data_in_cols = {5'd31, 5'd0, 5'd4, 5'd3};
    data_in_rows = '0;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("range valid", out_valid, 4'b1010);
    check("range cols", data_out_cols, {5'd27, 5'd28, 5'd0, 5'd31});
    check("range data", data_out, {16'd1, 16'd0, 16'd1, 16'd0});

    // Zero activation on lane 2.
`ifdef ZERO_SKIP_EN
    zero_lane_valid = 4'b1011;
`else
    zero_lane_valid = 4'b1111;
`endif
    weight       = 16'd2;
    weight_cols  = '0;
    data_in_cols = '0;
    data_in      = {16'd9, 16'd0, 16'd7, 16'd5};
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("zero valid", out_valid, zero_lane_valid);
    check("zero data", data_out, {16'd18, 16'd0, 16'd14, 16'd10});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
